// File: rtl/pipeline_0_decode_reg.sv
// Decode stage register: decodes a 16-bit instruction and holds the result in a
// two-entry skid buffer so the stage can absorb one cycle of downstream backpressure.
module pipeline_0_decode_reg #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       ir_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W+13:0]  control_out,
  output logic [2:0]        num_rm,
  output logic [2:0]        num_rn,
  output logic [2:0]        num_rd,
  output logic [DATA_W-1:0] sximm,
  output logic              illegal
);

  localparam int CTRL_W  = PC_W + 14;
  localparam int ENTRY_W = 1 + CTRL_W + 9 + DATA_W;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDR = 3'b011;
  localparam logic [2:0] OP_STR = 3'b100;
  localparam logic [2:0] OP_ALU = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;

  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_MVN = 2'b11;
  localparam logic [1:0] MOV_IMM = 2'b10;

  logic [2:0]        dec_opcode;
  logic              dec_asel;
  logic              dec_bsel;
  logic              dec_loads;
  logic [1:0]        dec_aluop;
  logic [1:0]        dec_shift;
  logic              dec_write;
  logic [2:0]        dec_writenum;
  logic [2:0]        dec_rm;
  logic [2:0]        dec_rn;
  logic [2:0]        dec_rd;
  logic [DATA_W-1:0] dec_sximm;
  logic              dec_illegal;
  logic [DATA_W-1:0] sext8;
  logic [DATA_W-1:0] sext5;
  logic [ENTRY_W-1:0] dec_entry;

  logic               main_valid;
  logic               skid_valid;
  logic [ENTRY_W-1:0] main_q;
  logic [ENTRY_W-1:0] skid_q;
  logic               accept;
  logic               main_free;

  assign sext8 = {{(DATA_W-8){ir_in[7]}}, ir_in[7:0]};
  assign sext5 = {{(DATA_W-5){ir_in[4]}}, ir_in[4:0]};

  always_comb begin
    dec_opcode   = ir_in[15:13];
    dec_asel     = 1'b0;
    dec_bsel     = 1'b0;
    dec_loads    = 1'b0;
    dec_aluop    = 2'b00;
    dec_shift    = 2'b00;
    dec_write    = 1'b0;
    dec_writenum = 3'b000;
    dec_rm       = 3'b000;
    dec_rn       = 3'b000;
    dec_rd       = 3'b000;
    dec_sximm    = '0;
    dec_illegal  = 1'b0;
    case (dec_opcode)
      OP_NOP: ;
      OP_MOV: begin
        dec_bsel  = 1'b1;
        dec_write = 1'b1;
        if (ir_in[12:11] == MOV_IMM) begin
          dec_asel     = 1'b1;
          dec_writenum = ir_in[10:8];
          dec_sximm    = sext8;
        end else begin
          dec_writenum = ir_in[7:5];
          dec_shift    = ir_in[4:3];
          dec_rm       = ir_in[2:0];
        end
      end
      OP_ALU: begin
        dec_aluop = ir_in[12:11];
        dec_shift = ir_in[4:3];
        dec_rm    = ir_in[2:0];
        if (ir_in[12:11] == ALU_CMP) begin
          dec_rn    = ir_in[10:8];
          dec_loads = 1'b1;
        end else begin
          dec_write    = 1'b1;
          dec_writenum = ir_in[7:5];
          if (ir_in[12:11] != ALU_MVN) dec_rn = ir_in[10:8];
        end
      end
      OP_STR: begin
        dec_bsel  = 1'b1;
        dec_rm    = ir_in[10:8];
        dec_rd    = ir_in[7:5];
        dec_sximm = sext5;
      end
      OP_LDR: begin
        dec_bsel     = 1'b1;
        dec_rm       = ir_in[10:8];
        dec_write    = 1'b1;
        dec_writenum = ir_in[7:5];
        dec_sximm    = sext5;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign dec_entry = {dec_illegal,
                      dec_opcode, pc_in, dec_asel, dec_bsel, dec_loads,
                      dec_aluop, dec_shift, dec_write, dec_writenum,
                      dec_rm, dec_rn, dec_rd, dec_sximm};

  assign accept    = in_valid && in_ready;
  assign main_free = !main_valid || out_ready;

  // Main is refilled from skid first so order is kept; skid only fills while main stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_q     <= skid_q;
        skid_valid <= 1'b0;
        skid_q     <= '0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_q     <= dec_entry;
      end else begin
        main_valid <= 1'b0;
        main_q     <= '0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_q     <= dec_entry;
    end
  end

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign {illegal, control_out, num_rm, num_rn, num_rd, sximm} = main_q;

endmodule
